// File: rtl/handed_pkg.sv
// Shared definitions for the handed tracker / turn sequencer.
//   phase_t     : sequencer state encoding, also driven onto the phase port
//   ROUND_CNT_W : width of the saturating completed-round counter
//   MAX_PLAYERS : largest supported player count
package handed_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEALING   = 2'd1,
    PLAYING   = 2'd2,
    ROUND_END = 2'd3
  } phase_t;

  localparam int ROUND_CNT_W = 8;
  localparam int MAX_PLAYERS = 8;

endpackage

// File: rtl/handed_flag_bank.sv
// Bank of per-player "holds a hand" flags.
//   clk, reset : system clock, asynchronous active-high reset
//   clr_all    : synchronous clear of every flag (wins over set/clear)
//   set_en/idx : set the flag of player set_idx
//   clr_en/idx : clear the flag of player clr_idx
//   flags      : registered flag vector, bit p = player p
//   all_ones   : combinational AND of all flags
// Indices outside 0..NUM_PLAYERS-1 simply match no flag.
module handed_flag_bank
  import handed_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  localparam int PW = $clog2(NUM_PLAYERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_all,
  input  logic                   set_en,
  input  logic [PW-1:0]          set_idx,
  input  logic                   clr_en,
  input  logic [PW-1:0]          clr_idx,
  output logic [NUM_PLAYERS-1:0] flags,
  output logic                   all_ones
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (clr_all) begin
      flags <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (set_en && (set_idx == PW'(i))) begin
          flags[i] <= 1'b1;
        end else if (clr_en && (clr_idx == PW'(i))) begin
          flags[i] <= 1'b0;
        end
      end
    end
  end

  assign all_ones = &flags;

endmodule

// File: rtl/handed_sequencer.sv
// Per-player handed tracker and turn sequencer.
//   clk, reset  : system clock, asynchronous active-high reset
//   new_game    : synchronous restart into DEALING, overrides everything
//   deal_valid  : deal event to player deal_player (honoured in DEALING)
//   turn_done   : current player ended the turn (honoured in PLAYING)
//   handed      : bit p set while player p holds a hand
//   all_handed  : combinational AND of handed
//   turn_player : index of the player whose turn it is
//   round_done  : one-cycle pulse, high exactly during ROUND_END
//   round_cnt   : completed rounds, saturating at 255
//   err         : one-cycle pulse on a duplicate or out-of-range deal
//   phase       : current state (handed_pkg::phase_t encoding)
module handed_sequencer
  import handed_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  localparam int PW = $clog2(NUM_PLAYERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_game,
  input  logic                   deal_valid,
  input  logic [PW-1:0]          deal_player,
  input  logic                   turn_done,
  output logic [NUM_PLAYERS-1:0] handed,
  output logic                   all_handed,
  output logic [PW-1:0]          turn_player,
  output logic                   round_done,
  output logic [ROUND_CNT_W-1:0] round_cnt,
  output logic                   err,
  output logic [1:0]             phase
);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > MAX_PLAYERS) begin : g_bad_num_players
    $error("handed_sequencer: NUM_PLAYERS must be in 2..8");
  end

  function automatic logic [ROUND_CNT_W-1:0] sat_inc(input logic [ROUND_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  phase_t                 state;
  logic                   in_range;
  logic                   dup;
  logic [NUM_PLAYERS-1:0] set_mask;
  logic                   deal_ok;
  logic                   deal_err;
  logic                   deal_fills;
  logic                   turn_ok;
  logic                   last_turn;
  logic                   bank_all;

  // Decode the deal target without indexing past the flag vector when the
  // requested player does not exist.
  always_comb begin
    in_range = 1'b0;
    dup      = 1'b0;
    set_mask = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (deal_player == PW'(i)) begin
        in_range    = 1'b1;
        dup         = handed[i];
        set_mask[i] = 1'b1;
      end
    end
  end

  assign deal_ok    = (state == DEALING) && deal_valid && !new_game && in_range && !dup;
  assign deal_err   = (state == DEALING) && deal_valid && !new_game && (!in_range || dup);
  // The last deal moves to PLAYING on the same edge that fills the bank.
  assign deal_fills = deal_ok && (&(handed | set_mask));
  assign turn_ok    = (state == PLAYING) && turn_done && !new_game;
  assign last_turn  = (turn_player == PW'(NUM_PLAYERS - 1));

  handed_flag_bank #(
    .NUM_PLAYERS(NUM_PLAYERS)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .clr_all  (new_game),
    .set_en   (deal_ok),
    .set_idx  (deal_player),
    .clr_en   (turn_ok),
    .clr_idx  (turn_player),
    .flags    (handed),
    .all_ones (bank_all)
  );

  assign all_handed = bank_all;
  assign phase      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (new_game) begin
      state <= DEALING;
    end else begin
      unique case (state)
        IDLE:      state <= IDLE;
        DEALING:   if (deal_fills) state <= PLAYING;
        PLAYING:   if (turn_ok && last_turn) state <= ROUND_END;
        ROUND_END: state <= DEALING;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turn_player <= '0;
      round_cnt   <= '0;
    end else if (new_game) begin
      turn_player <= '0;
      round_cnt   <= '0;
    end else if (deal_fills) begin
      turn_player <= '0;
    end else if (turn_ok) begin
      if (last_turn) begin
        turn_player <= '0;
        round_cnt   <= sat_inc(round_cnt);
      end else begin
        turn_player <= turn_player + 1'b1;
      end
    end
  end

  // Pulses are registered from the triggering event, so each lasts exactly
  // the one cycle following that event's edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      round_done <= turn_ok && last_turn;
      err        <= deal_err;
    end
  end

endmodule
